// File: rtl/mips_pkg.sv
// mips_pkg: shared definitions for the single-cycle MIPS datapath.
//   DATA_W / ADDR_W : default word and register-index widths
//   REG_ZERO / REG_SP / REG_RA : architectural register indices
//   word_t / reg_idx_t : convenience types at the default widths
package mips_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  localparam int REG_ZERO = 0;
  localparam int REG_SP   = 29;
  localparam int REG_RA   = 31;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] reg_idx_t;

endpackage

// File: rtl/reg_file_rd_port.sv
// reg_file_rd_port: one combinational read port of the register file.
//   index   : register index to read
//   storage : flop contents of registers 1..2^ADDR_W-1 (register 0 has none)
//   data    : selected register value, forced to 0 for index 0
// Optional feature (macro REGFILE_BYPASS_EN): adds the write-port inputs
//   rst_n, wr_en, wr_reg, wr_data so a same-cycle write to the addressed
//   register is forwarded straight to data.
module reg_file_rd_port #(
  parameter int DATA_W = mips_pkg::DATA_W,
  parameter int ADDR_W = mips_pkg::ADDR_W
) (
  input  logic [ADDR_W-1:0] index,
  input  logic [DATA_W-1:0] storage [1:(2**ADDR_W)-1],
`ifdef REGFILE_BYPASS_EN
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_reg,
  input  logic [DATA_W-1:0] wr_data,
`endif
  output logic [DATA_W-1:0] data
);
  import mips_pkg::*;

  always_comb begin
    data = '0;
    if (index != ADDR_W'(REG_ZERO)) begin
      data = storage[index];
`ifdef REGFILE_BYPASS_EN
      // index is known non-zero here, so a match implies wr_reg is non-zero too
      if (rst_n && wr_en && (wr_reg == index)) begin
        data = wr_data;
      end
`endif
    end
  end

endmodule

// File: rtl/reg_file.sv
// reg_file: 32 x 32-bit MIPS general-purpose register file.
//   CLK       : clock, writes commit on the rising edge
//   RST_N     : asynchronous active-low reset ($sp loads SP_RESET, others 0)
//   ReadReg1  : read port 1 index (rs) -> ReadData1 (ALU A)
//   ReadReg2  : read port 2 index (rt) -> ReadData2 (ALU B / store data)
//   RegWre    : write enable
//   WriteReg  : write index; writes to index 0 are discarded
//   WriteData : write-back value
// Optional feature (macro REGFILE_BYPASS_EN): write-through bypass from the
//   write port to both read ports in the same cycle.
module reg_file #(
  parameter int                DATA_W   = mips_pkg::DATA_W,
  parameter int                ADDR_W   = mips_pkg::ADDR_W,
  parameter logic [DATA_W-1:0] SP_RESET = '0
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [ADDR_W-1:0] ReadReg1,
  input  logic [ADDR_W-1:0] ReadReg2,
  input  logic              RegWre,
  input  logic [ADDR_W-1:0] WriteReg,
  input  logic [DATA_W-1:0] WriteData,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2
);
  import mips_pkg::*;

  localparam int DEPTH = 2**ADDR_W;

  // Register 0 is never stored; the array starts at index 1.
  logic [DATA_W-1:0] regs [1:DEPTH-1];

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 1; i < DEPTH; i++) begin
        regs[i] <= (i == REG_SP) ? SP_RESET : '0;
      end
    end else if (RegWre && (WriteReg != ADDR_W'(REG_ZERO))) begin
      regs[WriteReg] <= WriteData;
    end
  end

  reg_file_rd_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) port1 (
    .index   (ReadReg1),
    .storage (regs),
`ifdef REGFILE_BYPASS_EN
    .rst_n   (RST_N),
    .wr_en   (RegWre),
    .wr_reg  (WriteReg),
    .wr_data (WriteData),
`endif
    .data    (ReadData1)
  );

  reg_file_rd_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) port2 (
    .index   (ReadReg2),
    .storage (regs),
`ifdef REGFILE_BYPASS_EN
    .rst_n   (RST_N),
    .wr_en   (RegWre),
    .wr_reg  (WriteReg),
    .wr_data (WriteData),
`endif
    .data    (ReadData2)
  );

endmodule
